fighter_anim_ctrl: RTL and testbench

FIGHTER_ANIM_CTRL -- requirements
Module: fighter_anim_ctrl

---
 rtl/fighter_anim_ctrl_pkg.sv | 32 +++
 rtl/fighter_anim_ctrl_if.sv | 25 ++
 rtl/fighter_anim_ctrl_sprite_window.sv | 48 ++++
 rtl/fighter_anim_ctrl.sv | 102 ++++++++++
 tb/tb_fighter_anim_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fighter_anim_ctrl_pkg.sv
// Shared types and constants for the fighter animation controller.
package fighter_pkg;

    typedef enum logic [1:0] {
        ST_STAND  = 2'd0,
        ST_WALK   = 2'd1,
        ST_ATTACK = 2'd2
    } state_t;

    localparam logic [2:0] SPR_STAND0 = 3'd0;
    localparam logic [2:0] SPR_STAND1 = 3'd1;
    localparam logic [2:0] SPR_WALK0  = 3'd2;
    localparam logic [2:0] SPR_WALK1  = 3'd3;
    localparam logic [2:0] SPR_ATK0   = 3'd4;
    localparam logic [2:0] SPR_ATK1   = 3'd5;
    localparam logic [2:0] SPR_ATK2   = 3'd6;

    localparam int DEF_SPR_W = 64;
    localparam int DEF_SPR_H = 64;

    // Sprite ROM/palette index for a given animation state and step.
    function automatic logic [2:0] sel_of(input state_t st, input logic [2:0] step);
        logic [2:0] sel;
        case (st)
            ST_WALK:   sel = SPR_WALK0 + step;
            ST_ATTACK: sel = SPR_ATK0 + step;
            default:   sel = SPR_STAND0 + step;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fighter_anim_ctrl_if.sv
// Control, position, pixel and sprite-select signals of the fighter animation controller.
interface fighter_anim_ctrl_if;
    logic        frame_tick;
    logic        move_l;
    logic        move_r;
    logic        attack;
    logic [9:0]  fighter_x;
    logic [9:0]  fighter_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [2:0]  sprite_sel;
    logic [11:0] rom_address;
    logic        sprite_on;
    logic        busy;

    modport master (
        output frame_tick, move_l, move_r, attack, fighter_x, fighter_y, DrawX, DrawY,
        input  sprite_sel, rom_address, sprite_on, busy
    );

    modport slave (
        input  frame_tick, move_l, move_r, attack, fighter_x, fighter_y, DrawX, DrawY,
        output sprite_sel, rom_address, sprite_on, busy
    );
endinterface

// File: rtl/fighter_anim_ctrl_sprite_window.sv
// Sprite window hit test and ROM address generation, registered once.
module sprite_window import fighter_pkg::*; #(
    parameter int SPR_W = DEF_SPR_W,
    parameter int SPR_H = DEF_SPR_H
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [9:0]  lx,
    input  logic [9:0]  ly,
    output logic        sprite_on_o,
    output logic [11:0] rom_address_o
);
    localparam int XS = $clog2(SPR_W);

    logic [10:0] x11, y11, lx11, ly11, dx, dy;
    logic [21:0] addr_full;
    logic        hit_d, hit_q;
    logic [11:0] addr_d, addr_q;

    // 11-bit arithmetic so a sprite near x=1023 does not wrap to the left edge.
    always_comb begin
        x11       = {1'b0, draw_x};
        y11       = {1'b0, draw_y};
        lx11      = {1'b0, lx};
        ly11      = {1'b0, ly};
        dx        = x11 - lx11;
        dy        = y11 - ly11;
        hit_d     = (x11 >= lx11) && (x11 < lx11 + 11'(SPR_W)) &&
                    (y11 >= ly11) && (y11 < ly11 + 11'(SPR_H));
        addr_full = ({11'b0, dy} << XS) + {11'b0, dx};
        addr_d    = hit_d ? addr_full[11:0] : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hit_q  <= 1'b0;
            addr_q <= 12'd0;
        end else begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign sprite_on_o   = hit_q;
    assign rom_address_o = addr_q;
endmodule

// File: rtl/fighter_anim_ctrl.sv
// Fighter animation state machine (STAND/WALK/ATTACK) with frame-latched sprite window.
module fighter_anim_ctrl import fighter_pkg::*; #(
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int HOLD_FRAMES = 8,
    parameter int ATK_STEPS   = 3
) (
    input logic                vga_clk,
    input logic                reset,
    fighter_anim_ctrl_if.slave bus
);
    localparam int         HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);
    localparam logic [2:0] STEP_LAST = 3'(ATK_STEPS - 1);

    state_t        state_q, state_d, target;
    logic [2:0]    step_q, step_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [9:0]    lx_q, lx_d, ly_q, ly_d;
    logic [2:0]    sel_q;
    logic          busy_q;
    logic          hold_wrap;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        hold_d    = hold_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        hold_wrap = (hold_q == HOLD_MAX);
        if (bus.attack)
            target = ST_ATTACK;
        else if (bus.move_l ^ bus.move_r)
            target = ST_WALK;
        else
            target = ST_STAND;

        if (bus.frame_tick) begin
            lx_d = bus.fighter_x;
            ly_d = bus.fighter_y;
            if (state_q == ST_ATTACK) begin
                // Attack runs to completion; the final wrap re-enters as if from STAND.
                if (hold_wrap && step_q == STEP_LAST) begin
                    state_d = target;
                    step_d  = 3'd0;
                    hold_d  = '0;
                end else if (hold_wrap) begin
                    hold_d = '0;
                    step_d = step_q + 3'd1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end else if (target != state_q) begin
                state_d = target;
                step_d  = 3'd0;
                hold_d  = '0;
            end else if (hold_wrap) begin
                hold_d = '0;
                step_d = {2'b00, ~step_q[0]};
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= ST_STAND;
            step_q  <= 3'd0;
            hold_q  <= '0;
            lx_q    <= 10'd0;
            ly_q    <= 10'd0;
            sel_q   <= SPR_STAND0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            sel_q   <= sel_of(state_d, step_d);
            busy_q  <= (state_d == ST_ATTACK);
        end
    end

    sprite_window #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_window (
        .clk           (vga_clk),
        .srst          (reset),
        .draw_x        (bus.DrawX),
        .draw_y        (bus.DrawY),
        .lx            (lx_q),
        .ly            (ly_q),
        .sprite_on_o   (bus.sprite_on),
        .rom_address_o (bus.rom_address)
    );

    assign bus.sprite_sel = sel_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed self-checking bench for fighter_anim_ctrl (defaults: 64x64, HOLD_FRAMES=8, ATK_STEPS=3).
module tb_fighter_anim_ctrl;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    fighter_anim_ctrl_if ifc();

    fighter_anim_ctrl dut (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_tick();
        @(negedge clk);
        ifc.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        ifc.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.move_l = 1'b0;
        ifc.move_r = 1'b0;
        ifc.attack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.frame_tick = 1'b1;
        ifc.attack = 1'b1;
        ifc.DrawX = 10'd0;
        ifc.DrawY = 10'd0;
        @(posedge clk);
        #1;
        tests_run++;
        if (ifc.sprite_sel !== 3'd0 || ifc.busy !== 1'b0 || ifc.sprite_on !== 1'b0 || ifc.rom_address !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_state: sel=%0d busy=%0b on=%0b addr=%0d, required 0 0 0 0",
                     ifc.sprite_sel, ifc.busy, ifc.sprite_on, ifc.rom_address);
        end
        ifc.frame_tick = 1'b0;
        ifc.attack = 1'b0;
        reset = 1'b0;
        $display("[TB] reset: sel=%0d busy=%0b", ifc.sprite_sel, ifc.busy);
    endtask

    task automatic test_stand_toggle();
        logic [2:0] exp_sel;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            do_tick();
            exp_sel = (i >= 8 && i < 16) ? 3'd1 : 3'd0;
            tests_run++;
            if (ifc.sprite_sel !== exp_sel) begin
                tests_failed++;
                $display("FAIL stand_toggle tick %0d: sel=%0d required %0d", i, ifc.sprite_sel, exp_sel);
            end
            $display("[TB] stand tick %0d: sel=%0d", i, ifc.sprite_sel);
        end
    endtask

    task automatic test_walk();
        logic [2:0] exp_sel;
        do_reset();
        ifc.move_r = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            do_tick();
            exp_sel = (i == 8) ? 3'd3 : 3'd2;
            tests_run++;
            if (ifc.sprite_sel !== exp_sel || ifc.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL walk tick %0d: sel=%0d busy=%0b required %0d 0", i, ifc.sprite_sel, ifc.busy, exp_sel);
            end
            $display("[TB] walk tick %0d: sel=%0d", i, ifc.sprite_sel);
        end
        ifc.move_l = 1'b1;
        do_tick();
        tests_run++;
        if (ifc.sprite_sel !== 3'd0) begin
            tests_failed++;
            $display("FAIL walk_both_moves: sel=%0d required 0", ifc.sprite_sel);
        end
        $display("[TB] both moves: sel=%0d", ifc.sprite_sel);
        ifc.move_r = 1'b0;
        do_tick();
        tests_run++;
        if (ifc.sprite_sel !== 3'd2) begin
            tests_failed++;
            $display("FAIL walk_left: sel=%0d required 2", ifc.sprite_sel);
        end
        $display("[TB] move_l: sel=%0d", ifc.sprite_sel);
        ifc.move_l = 1'b0;
    endtask

    task automatic test_attack(input logic hold_attack);
        logic [2:0] exp_sel;
        logic       exp_busy;
        do_reset();
        ifc.attack = 1'b1;
        do_tick();
        ifc.attack = hold_attack;
        ifc.move_r = ~hold_attack;
        tests_run++;
        if (ifc.sprite_sel !== 3'd4 || ifc.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL attack_start: sel=%0d busy=%0b required 4 1", ifc.sprite_sel, ifc.busy);
        end
        for (int k = 1; k <= 24; k++) begin
            if (k == 24) ifc.move_r = 1'b0;
            do_tick();
            if (k < 24) begin
                exp_sel  = 3'(4 + k / 8);
                exp_busy = 1'b1;
            end else begin
                exp_sel  = hold_attack ? 3'd4 : 3'd0;
                exp_busy = hold_attack;
            end
            tests_run++;
            if (ifc.sprite_sel !== exp_sel || ifc.busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL attack held=%0b tick %0d: sel=%0d busy=%0b required %0d %0b",
                         hold_attack, k, ifc.sprite_sel, ifc.busy, exp_sel, exp_busy);
            end
            $display("[TB] attack held=%0b tick %0d: sel=%0d busy=%0b", hold_attack, k, ifc.sprite_sel, ifc.busy);
        end
        ifc.attack = 1'b0;
    endtask

    task automatic test_window();
        logic [9:0]  vx[7]  = '{10'd163, 10'd164, 10'd100, 10'd99, 10'd163, 10'd110, 10'd100};
        logic [9:0]  vy[7]  = '{10'd113, 10'd113, 10'd50, 10'd50, 10'd114, 10'd60, 10'd49};
        logic        von[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [11:0] vad[7] = '{12'd4095, 12'd0, 12'd0, 12'd0, 12'd0, 12'd650, 12'd0};
        do_reset();
        ifc.fighter_x = 10'd100;
        ifc.fighter_y = 10'd50;
        do_tick();
        // Position inputs move between ticks; the window must keep the latched values.
        ifc.fighter_x = 10'd0;
        ifc.fighter_y = 10'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ifc.DrawX = vx[i];
            ifc.DrawY = vy[i];
            #1;
            if (i > 0) begin
                tests_run++;
                if (ifc.sprite_on !== von[i-1]) begin
                    tests_failed++;
                    $display("FAIL window_latency %0d: on=%0b before edge, required %0b", i, ifc.sprite_on, von[i-1]);
                end
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (ifc.sprite_on !== von[i] || ifc.rom_address !== vad[i]) begin
                tests_failed++;
                $display("FAIL window (%0d,%0d): on=%0b addr=%0d required %0b %0d",
                         vx[i], vy[i], ifc.sprite_on, ifc.rom_address, von[i], vad[i]);
            end
            $display("[TB] window (%0d,%0d): on=%0b addr=%0d", vx[i], vy[i], ifc.sprite_on, ifc.rom_address);
        end
    endtask

    task automatic test_right_edge();
        logic [9:0]  vx[3]  = '{10'd1023, 10'd5, 10'd1023};
        logic [9:0]  vy[3]  = '{10'd5, 10'd5, 10'd64};
        logic        von[3] = '{1'b1, 1'b0, 1'b0};
        logic [11:0] vad[3] = '{12'd343, 12'd0, 12'd0};
        ifc.fighter_x = 10'd1000;
        ifc.fighter_y = 10'd0;
        do_tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc.DrawX = vx[i];
            ifc.DrawY = vy[i];
            @(posedge clk);
            #1;
            tests_run++;
            if (ifc.sprite_on !== von[i] || ifc.rom_address !== vad[i]) begin
                tests_failed++;
                $display("FAIL right_edge (%0d,%0d): on=%0b addr=%0d required %0b %0d",
                         vx[i], vy[i], ifc.sprite_on, ifc.rom_address, von[i], vad[i]);
            end
            $display("[TB] right edge (%0d,%0d): on=%0b addr=%0d", vx[i], vy[i], ifc.sprite_on, ifc.rom_address);
        end
    endtask

    task automatic test_reset_mid_attack();
        do_reset();
        ifc.attack = 1'b1;
        do_tick();
        ifc.attack = 1'b0;
        for (int k = 0; k < 10; k++) do_tick();
        tests_run++;
        if (ifc.sprite_sel !== 3'd5 || ifc.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_attack: sel=%0d busy=%0b required 5 1", ifc.sprite_sel, ifc.busy);
        end
        @(negedge clk);
        reset = 1'b1;
        ifc.frame_tick = 1'b1;
        ifc.attack = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ifc.frame_tick = 1'b0;
        ifc.attack = 1'b0;
        tests_run++;
        if (ifc.sprite_sel !== 3'd0 || ifc.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_dominates_tick: sel=%0d busy=%0b required 0 0", ifc.sprite_sel, ifc.busy);
        end
        $display("[TB] reset mid-attack: sel=%0d busy=%0b", ifc.sprite_sel, ifc.busy);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            tests_run++;
            if (ifc.sprite_sel !== ((k == 8) ? 3'd1 : 3'd0) || ifc.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset tick %0d: sel=%0d busy=%0b required %0d 0",
                         k, ifc.sprite_sel, ifc.busy, (k == 8) ? 1 : 0);
            end
            $display("[TB] post-reset tick %0d: sel=%0d", k, ifc.sprite_sel);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        ifc.frame_tick = 1'b0;
        ifc.move_l     = 1'b0;
        ifc.move_r     = 1'b0;
        ifc.attack     = 1'b0;
        ifc.fighter_x  = 10'd0;
        ifc.fighter_y  = 10'd0;
        ifc.DrawX      = 10'd0;
        ifc.DrawY      = 10'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_stand_toggle();
        test_walk();
        test_attack(1'b0);
        test_attack(1'b1);
        test_window();
        test_right_edge();
        test_reset_mid_attack();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
